// File: rtl/seg7_scan_blink.sv
// seg7_scan_blink
//   Scans eight common-anode 7-segment digits from a 32-bit hex value. The value,
//   the per-digit blink mask and the decimal-point mask are captured together
//   once per scan frame, so a frame never shows a mix of old and new digits.
//   Blinking digits are blanked during the "dark" half of a slow blink cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   disp_data    hex value, digit i = disp_data[4i+3:4i]
//   blink        blink[i]=1 -> digit i blinks
//   dp           dp[i]=1 -> decimal point of digit i lit
//   AN           active-low digit enables, AN[i] = digit i
//   SEGMENT      active-low segments, [0]=a .. [6]=g, [7]=dp
//   frame_start  one-cycle pulse after a new snapshot is taken
module seg7_scan_blink #(
  parameter int unsigned SCAN_PERIOD  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_data,
  input  logic [7:0]  blink,
  input  logic [7:0]  dp,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_start
);

  localparam int SCAN_W  = (SCAN_PERIOD  > 1) ? $clog2(SCAN_PERIOD)  : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         digit_q, digit_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               phase_q, phase_d;

  logic [31:0] snap_data_q;
  logic [7:0]  snap_blink_q;
  logic [7:0]  snap_dp_q;
  logic        frame_start_q;

  // stage 1 carries the digit index and blink phase together, so a digit is
  // either fully blanked or fully shown for its whole slot
  logic        p1_valid_q;
  logic [2:0]  p1_digit_q;
  logic        p1_phase_q;

  logic [7:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;

  logic        scan_wrap;
  logic        frame_end;
  logic        capture;
  logic [3:0]  nibble;
  logic [6:0]  seg7;

  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_LAST);
    frame_end   = scan_wrap && (digit_q == 3'd7);
    capture     = (scan_cnt_q == '0) && (digit_q == 3'd0);

    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    digit_d     = scan_wrap ? digit_q + 3'd1 : digit_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  always_comb begin
    nibble = snap_data_q[{p1_digit_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase

    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if (p1_valid_q) begin
      an_d = ~(8'b1 << p1_digit_q);
      if (!(snap_blink_q[p1_digit_q] && p1_phase_q)) begin
        seg_d = {~snap_dp_q[p1_digit_q], seg7};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      digit_q       <= 3'd0;
      frame_cnt_q   <= '0;
      phase_q       <= 1'b0;
      snap_data_q   <= 32'h0;
      snap_blink_q  <= 8'h0;
      snap_dp_q     <= 8'h0;
      frame_start_q <= 1'b0;
      p1_valid_q    <= 1'b0;
      p1_digit_q    <= 3'd0;
      p1_phase_q    <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= 8'hFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_q       <= digit_d;
      frame_cnt_q   <= frame_cnt_d;
      phase_q       <= phase_d;
      frame_start_q <= capture;
      if (capture) begin
        snap_data_q  <= disp_data;
        snap_blink_q <= blink;
        snap_dp_q    <= dp;
      end
      p1_valid_q    <= 1'b1;
      p1_digit_q    <= digit_q;
      p1_phase_q    <= phase_q;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign AN          = an_q;
  assign SEGMENT     = seg_q;
  assign frame_start = frame_start_q;

endmodule
